fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo_rd_stream_if.sv | 14 +
 rtl/fifo_rd_stream.sv | 86 ++++++++
 tb/tb_fifo_rd_stream.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} rd_state_t;
  localparam int DROP_MAX = 255;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO show-ahead read port plus valid/ready stream.
//   rdata/rempty/rinc : FIFO head word, empty flag, pop strobe
//   m_data/m_valid/m_ready : outgoing stream
//   master modport = the adapter, slave modport = FIFO + stream sink
interface fifo_rd_stream_if #(parameter int DSIZE = 8);
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  modport master (input rdata, rempty, m_ready, output rinc, m_data, m_valid);
  modport slave (output rdata, rempty, m_ready, input rinc, m_data, m_valid);
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts a FIFO show-ahead read port into a valid/ready stream.
//   rclk, rrst_n : read clock, async active-low reset
//   bus          : FIFO read port and stream (master modport)
//   flush        : level-sensitive discard request
//   level        : buffered words 0..2
//   pop_cnt      : words accepted downstream, wrapping
//   drop_cnt     : words discarded by flush, saturating at 255
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  fifo_rd_stream_if.master      bus,
  input  logic                  flush,
  output logic [1:0]            level,
  output logic [CNTW-1:0]       pop_cnt,
  output logic [7:0]            drop_cnt
);
  rd_state_t        state_q, state_d;
  logic [DSIZE-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic             valid_q;
  logic [CNTW-1:0]  pop_q;
  logic [7:0]       drop_q, drop_d;
  logic [1:0]       drop_inc;
  logic [8:0]       drop_sum;
  logic             push, take;
  assign take = valid_q & bus.m_ready;
  // Pop depends only on registered state and flush, never on m_ready; reset gates it off.
  assign push = rrst_n & ~bus.rempty & (flush | (state_q != TWO));
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      pop_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= state_d != EMPTY;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      pop_q   <= pop_q + CNTW'(take);
      drop_q  <= drop_d;
    end
  end
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        buf0_d  = bus.rdata;
      end
      ONE: if (push && take) buf0_d = bus.rdata;
      else if (push) begin
        state_d = TWO;
        buf1_d  = bus.rdata;
      end else if (take) state_d = EMPTY;
      TWO: if (take) begin
        state_d = ONE;
        buf0_d  = buf1_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // A word taken during flush is delivered, not dropped; a word popped during flush is dropped.
  always_comb begin
    drop_inc = state_q - {1'b0, take} + {1'b0, push};
    drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
    drop_d   = !flush ? drop_q : drop_sum > 9'(DROP_MAX) ? 8'(DROP_MAX) : drop_sum[7:0];
  end
  always_comb begin
    bus.rinc    = push;
    bus.m_valid = valid_q;
    bus.m_data  = buf0_q;
    level       = state_q;
    pop_cnt     = pop_q;
    drop_cnt    = drop_q;
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed vectors and random stimulus against a queue-based reference model.
module tb_fifo_rd_stream;
  logic        clk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  level;
  logic [15:0] pop_cnt;
  logic [7:0]  drop_cnt;
  logic [1:0]  wlevel;
  logic [3:0]  wpop;
  logic [7:0]  wdrop;
  logic        wflush = 1'b0;
  fifo_rd_stream_if #(.DSIZE(8)) bus ();
  fifo_rd_stream_if #(.DSIZE(8)) wbus ();
  fifo_rd_stream #(.DSIZE(8), .CNTW(16)) u_dut (
    .rclk(clk), .rrst_n(rrst_n), .bus(bus), .flush(flush),
    .level(level), .pop_cnt(pop_cnt), .drop_cnt(drop_cnt)
  );
  fifo_rd_stream #(.DSIZE(8), .CNTW(4)) u_wrap (
    .rclk(clk), .rrst_n(rrst_n), .bus(wbus), .flush(wflush),
    .level(wlevel), .pop_cnt(wpop), .drop_cnt(wdrop)
  );
  always #5 clk = ~clk;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  fq[$];
  logic [7:0]  mq[$];
  logic [15:0] mpop = '0;
  int          mdrop = 0;
  typedef struct {
    logic        rdy;
    logic        fl;
    logic        rinc;
    logic        valid;
    logic [7:0]  data;
    logic [1:0]  lvl;
    logic [15:0] pop;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive_fifo();
    bus.rempty = fq.size() == 0;
    bus.rdata  = fq.size() != 0 ? fq[0] : 8'h00;
  endtask
  task automatic step(input logic rdy, input logic fl);
    logic       er, tk, dr;
    logic [7:0] hw;
    int         inc;
    bus.m_ready = rdy;
    flush = fl;
    drive_fifo();
    #1;
    er = fq.size() != 0 && (fl || mq.size() < 2);
    chk("rinc", bus.rinc, er);
    chk("m_valid", bus.m_valid, mq.size() != 0);
    chk("level", level, mq.size());
    if (mq.size() != 0) chk("m_data", bus.m_data, mq[0]);
    chk("pop_cnt", pop_cnt, mpop);
    chk("drop_cnt", drop_cnt, mdrop);
    tk = mq.size() != 0 && rdy;
    dr = bus.rinc;
    hw = bus.rdata;
    @(posedge clk);
    if (tk) mpop++;
    if (fl) begin
      inc = mq.size() - int'(tk) + int'(er);
      mdrop = mdrop + inc > 255 ? 255 : mdrop + inc;
      mq.delete();
    end else begin
      if (tk) void'(mq.pop_front());
      if (er) mq.push_back(hw);
    end
    if (dr && fq.size() != 0) void'(fq.pop_front());
    @(negedge clk);
  endtask
  task automatic do_reset();
    rrst_n = 1'b0;
    if (fq.size() == 0) fq.push_back(8'hA5);
    drive_fifo();
    #1;
    chk("rst_rinc", bus.rinc, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_pop", pop_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", bus.m_data, 0);
    fq.delete();
    mq.delete();
    mpop = '0;
    mdrop = 0;
    drive_fifo();
    @(negedge clk);
    @(negedge clk);
    rrst_n = 1'b1;
  endtask
  initial begin
    int cnt;
    logic [7:0] v;
    bus.m_ready = 1'b0;
    bus.rempty = 1'b1;
    bus.rdata = 8'h00;
    wbus.m_ready = 1'b0;
    wbus.rempty = 1'b1;
    wbus.rdata = 8'h5A;
    tbl[0]  = '{1, 0, 1, 0, 8'h00, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 8'h11, 1, 0};
    tbl[2]  = '{1, 0, 1, 1, 8'h22, 1, 1};
    tbl[3]  = '{1, 0, 0, 1, 8'h33, 1, 2};
    tbl[4]  = '{1, 0, 0, 0, 8'h00, 0, 3};
    tbl[5]  = '{0, 0, 1, 0, 8'h00, 0, 3};
    tbl[6]  = '{0, 0, 1, 1, 8'h44, 1, 3};
    tbl[7]  = '{0, 0, 0, 1, 8'h44, 2, 3};
    tbl[8]  = '{0, 0, 0, 1, 8'h44, 2, 3};
    tbl[9]  = '{1, 0, 0, 1, 8'h44, 2, 3};
    tbl[10] = '{1, 0, 1, 1, 8'h55, 1, 4};
    tbl[11] = '{1, 0, 1, 1, 8'h66, 1, 5};
    tbl[12] = '{1, 0, 0, 1, 8'h77, 1, 6};
    tbl[13] = '{1, 0, 0, 0, 8'h00, 0, 7};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); end
      if (i == 5) begin fq.push_back(8'h44); fq.push_back(8'h55); fq.push_back(8'h66); fq.push_back(8'h77); end
      bus.m_ready = tbl[i].rdy;
      flush = tbl[i].fl;
      drive_fifo();
      #1;
      chk($sformatf("vec%0d_rinc", i), bus.rinc, tbl[i].rinc);
      chk($sformatf("vec%0d_valid", i), bus.m_valid, tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("vec%0d_data", i), bus.m_data, tbl[i].data);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_pop", i), pop_cnt, tbl[i].pop);
      step(tbl[i].rdy, tbl[i].fl);
    end
    do_reset();
    for (int i = 0; i < 7; i++) fq.push_back(8'(8'h80 + i));
    step(0, 0);
    step(0, 0);
    chk("flush_pre_level", level, 2);
    chk("flush_pre_fifo", fq.size(), 5);
    step(0, 1);
    chk("flush_valid_off", bus.m_valid, 0);
    for (int i = 0; i < 20 && fq.size() != 0; i++) step(0, 1);
    chk("flush_fifo_drained", fq.size(), 0);
    chk("flush_drop", drop_cnt, 7);
    step(1, 0);
    do_reset();
    for (int i = 0; i < 300; i++) fq.push_back(8'(i));
    for (int i = 0; i < 400 && fq.size() != 0; i++) step(1'($urandom_range(0, 1)), 1);
    step(0, 1);
    chk("sat_fifo_drained", fq.size(), 0);
    chk("sat_drop", drop_cnt, 255);
    do_reset();
    wbus.rempty = 1'b0;
    wbus.m_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (wbus.m_valid && wbus.m_ready) cnt++;
      if (cnt == 17) break;
      @(negedge clk);
    end
    chk("wrap_takes", cnt, 17);
    @(posedge clk);
    #1;
    chk("wrap_pop", wpop, 1);
    wbus.rempty = 1'b1;
    wbus.m_ready = 1'b0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0 && fq.size() < 8) begin
        v = 8'($urandom);
        fq.push_back(v);
      end
      if ($urandom_range(0, 799) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
